// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the audio stream controller.
// Holds the controller state encoding and counter width helpers.
package audio_stream_pkg;

    typedef enum logic [2:0] {
        S_BEGIN,
        S_SETUP,
        S_RETRY,
        S_PRIME,
        S_PLAY,
        S_FAULT
    } state_e;

    localparam int UNDERRUN_W = 16;

    // Bits needed for a counter that spans 0..n-1 (minimum 1).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with wrapping pointers and an occupancy count.
// Push while full and pop while empty are silently dropped.
module audio_frame_fifo #(
    parameter int FRAME_W = 32,
    parameter int DEPTH   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [FRAME_W-1:0]       data_i,
    input  logic                     pop_i,
    output logic [FRAME_W-1:0]       data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wptr_q;
    logic [AW-1:0]      rptr_q;
    logic [AW:0]        count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_stream_controller.sv
// Codec init sequencer with retry/fault plus primed frame streaming.
// Define AUDIO_VOLUME_EN to add the VOLUME attenuation port.
module audio_stream_controller
    import audio_stream_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int PRIME_LEVEL  = 4,
    parameter int INIT_TIMEOUT = 1000000,
    parameter int MAX_RETRIES  = 3,
    parameter int RETRY_GAP    = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         INIT_FINISH,
    output logic                         INIT,
    input  logic [NUM_CH*SAMPLE_W-1:0]   IN_DATA,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic                         FRAME_REQ,
    output logic [NUM_CH*SAMPLE_W-1:0]   DAC_DATA,
    output logic                         PLAYING,
    output logic                         FAULT,
    output logic [UNDERRUN_W-1:0]        UNDERRUN_CNT
`ifdef AUDIO_VOLUME_EN
    ,
    input  logic [2:0]                   VOLUME
`endif
);

    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int TW      = cnt_w(INIT_TIMEOUT);
    localparam int RW      = cnt_w(MAX_RETRIES + 1);
    localparam int GW      = cnt_w(RETRY_GAP);

    localparam logic [TW-1:0] TMO_LAST = TW'(INIT_TIMEOUT - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);
    localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);
    localparam logic [CW-1:0] PRIME_N  = CW'(PRIME_LEVEL);

    state_e                state_q, state_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [RW-1:0]         rty_q, rty_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [FRAME_W-1:0]    dac_q, dac_d;
    logic [UNDERRUN_W-1:0] urun_q, urun_d;

    logic                  stream_en;
    logic                  push;
    logic                  pop;
    logic                  req_play;
    logic [FRAME_W-1:0]    head;
    logic [FRAME_W-1:0]    shaped;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;

    audio_frame_fifo #(
        .FRAME_W (FRAME_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .data_i  (IN_DATA),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        rty_d     = rty_q;
        gap_d     = gap_q;
        INIT      = 1'b0;
        PLAYING   = 1'b0;
        FAULT     = 1'b0;
        stream_en = 1'b0;
        unique case (state_q)
            S_BEGIN: begin
                tmo_d   = '0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                INIT  = 1'b1;
                tmo_d = tmo_q + 1'b1;
                if (INIT_FINISH) begin
                    state_d = S_PRIME;
                end else if (tmo_q == TMO_LAST) begin
                    if (rty_q == RTY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        rty_d   = rty_q + 1'b1;
                        gap_d   = '0;
                        state_d = S_RETRY;
                    end
                end
            end
            S_RETRY: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    tmo_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_PRIME: begin
                INIT      = 1'b1;
                stream_en = 1'b1;
                if (count >= PRIME_N) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                INIT      = 1'b1;
                PLAYING   = 1'b1;
                stream_en = 1'b1;
            end
            S_FAULT: begin
                FAULT = 1'b1;
            end
            default: begin
                state_d = S_BEGIN;
            end
        endcase
    end

    // Ready ignores FRAME_REQ: a full FIFO refuses even on a pop cycle.
    assign IN_READY = stream_en && !full;
    assign push     = IN_VALID && IN_READY;
    assign req_play = FRAME_REQ && (state_q == S_PLAY);
    assign pop      = req_play && !empty;

    always_comb begin
        shaped = head;
`ifdef AUDIO_VOLUME_EN
        for (int c = 0; c < NUM_CH; c++) begin
            shaped[c*SAMPLE_W +: SAMPLE_W] =
                $signed(head[c*SAMPLE_W +: SAMPLE_W]) >>> VOLUME;
        end
`endif
    end

    always_comb begin
        dac_d  = dac_q;
        urun_d = urun_q;
        if (req_play) begin
            if (!empty) begin
                dac_d = shaped;
            end else begin
                dac_d = '0;
                if (urun_q != '1) begin
                    urun_d = urun_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_BEGIN;
            tmo_q   <= '0;
            rty_q   <= '0;
            gap_q   <= '0;
            dac_q   <= '0;
            urun_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            gap_q   <= gap_d;
            dac_q   <= dac_d;
            urun_q  <= urun_d;
        end
    end

    assign DAC_DATA     = dac_q;
    assign UNDERRUN_CNT = urun_q;

endmodule

// File: tb/tb_audio_stream_controller.sv
// Directed scoreboard bench for audio_stream_controller.
// Covers init, retry/fault, priming, streaming, underrun and reset.
module tb_audio_stream_controller;

    localparam int SW    = 16;
    localparam int NC    = 2;
    localparam int FW    = SW * NC;
    localparam int DEPTH = 8;

    logic          Clk         = 1'b0;
    logic          Reset       = 1'b1;
    logic          INIT_FINISH = 1'b0;
    logic          IN_VALID    = 1'b0;
    logic          FRAME_REQ   = 1'b0;
    logic [FW-1:0] IN_DATA     = '0;
    logic          INIT;
    logic          IN_READY;
    logic          PLAYING;
    logic          FAULT;
    logic [FW-1:0] DAC_DATA;
    logic [15:0]   UNDERRUN_CNT;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]    VOLUME      = 3'd0;
`endif

    int            total = 0;
    int            bad   = 0;
    int            urun_exp = 0;
    logic [FW-1:0] sb [$];

    audio_stream_controller #(
        .SAMPLE_W     (SW),
        .NUM_CH       (NC),
        .FIFO_DEPTH   (DEPTH),
        .PRIME_LEVEL  (4),
        .INIT_TIMEOUT (20),
        .MAX_RETRIES  (1),
        .RETRY_GAP    (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .INIT_FINISH  (INIT_FINISH),
        .INIT         (INIT),
        .IN_DATA      (IN_DATA),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .FRAME_REQ    (FRAME_REQ),
        .DAC_DATA     (DAC_DATA),
        .PLAYING      (PLAYING),
        .FAULT        (FAULT),
        .UNDERRUN_CNT (UNDERRUN_CNT)
`ifdef AUDIO_VOLUME_EN
        ,
        .VOLUME       (VOLUME)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [FW-1:0] shape(input logic [FW-1:0] f);
`ifdef AUDIO_VOLUME_EN
        logic [FW-1:0]        r;
        logic signed [SW-1:0] s;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            s = f[c*SW +: SW];
            r[c*SW +: SW] = s >>> VOLUME;
        end
        return r;
`else
        return f;
`endif
    endfunction

    task automatic push(input logic [FW-1:0] d);
        logic acc;
        acc = (sb.size() < DEPTH);
        chk("in_ready", IN_READY, acc);
        IN_DATA  = d;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        if (acc) sb.push_back(d);
    endtask

    task automatic req(input logic also_push, input logic [FW-1:0] d);
        logic          acc;
        logic [FW-1:0] exp;
        acc       = also_push && (sb.size() < DEPTH);
        FRAME_REQ = 1'b1;
        IN_VALID  = also_push;
        IN_DATA   = d;
        if (sb.size() > 0) begin
            exp = shape(sb.pop_front());
        end else begin
            exp = '0;
            if (urun_exp < 65535) urun_exp++;
        end
        step();
        FRAME_REQ = 1'b0;
        IN_VALID  = 1'b0;
        if (acc) sb.push_back(d);
        chk("dac_data", DAC_DATA, exp);
        chk("underrun", UNDERRUN_CNT, urun_exp);
    endtask

    initial begin
        #7;
        chk("rst_init", INIT, 1'b0);
        chk("rst_ready", IN_READY, 1'b0);
        chk("rst_dac", DAC_DATA, 32'h0);
        chk("rst_play", PLAYING, 1'b0);
        chk("rst_fault", FAULT, 1'b0);
        chk("rst_urun", UNDERRUN_CNT, 16'h0);
        #1 Reset = 1'b0;

        step();
        chk("setup_init", INIT, 1'b1);
        chk("setup_ready", IN_READY, 1'b0);
        repeat (9) step();
        INIT_FINISH = 1'b1;
        step();
        chk("prime_init", INIT, 1'b1);
        chk("prime_ready", IN_READY, 1'b1);
        chk("prime_fault", FAULT, 1'b0);
        chk("prime_play", PLAYING, 1'b0);
        INIT_FINISH = 1'b0;
        step();
        chk("drop_ignored", INIT, 1'b1);

        push(32'h0001_0002);
        push(32'h0002_0003);
        push(32'h0003_0004);
        push(32'h0004_0005);
        step();
        chk("playing", PLAYING, 1'b1);
        chk("play_init", INIT, 1'b1);

        req(1'b0, '0);
        chk("first_frame", DAC_DATA, 32'h0001_0002);
        req(1'b0, '0);
        step();
        chk("dac_hold", DAC_DATA, 32'h0002_0003);

        for (int i = 0; i < 6; i++) begin
            push(32'h0005_0006 + i * 32'h0001_0001);
        end
        chk("full_ready", IN_READY, 1'b0);
        req(1'b1, 32'hDEAD_BEEF);
        chk("after_pop_ready", IN_READY, 1'b1);
        repeat (7) req(1'b0, '0);
        repeat (3) req(1'b0, '0);
        chk("urun3", UNDERRUN_CNT, 16'd3);
        chk("urun_dac", DAC_DATA, 32'h0);

`ifdef AUDIO_VOLUME_EN
        push({16'h4000, 16'h8000});
        VOLUME = 3'd2;
        req(1'b0, '0);
        VOLUME = 3'd0;
        chk("vol_ch0", DAC_DATA[15:0], 16'hE000);
        chk("vol_ch1", DAC_DATA[31:16], 16'h1000);
`endif

        FRAME_REQ = 1'b1;
        repeat (65531) @(posedge Clk);
        #1;
        urun_exp = 65534;
        chk("urun_near", UNDERRUN_CNT, 16'hFFFE);
        repeat (3) @(posedge Clk);
        #1;
        FRAME_REQ = 1'b0;
        urun_exp = 65535;
        chk("urun_sat", UNDERRUN_CNT, 16'hFFFF);
        chk("sat_dac", DAC_DATA, 32'h0);

        push(32'h1234_5678);
        req(1'b0, '0);
        #2 Reset = 1'b1;
        #1;
        chk("arst_dac", DAC_DATA, 32'h0);
        chk("arst_urun", UNDERRUN_CNT, 16'h0);
        chk("arst_play", PLAYING, 1'b0);
        chk("arst_init", INIT, 1'b0);
        chk("arst_ready", IN_READY, 1'b0);
        chk("arst_fault", FAULT, 1'b0);
        sb.delete();
        urun_exp = 0;
        #1 Reset = 1'b0;

        step();
        for (int i = 0; i < 20; i++) begin
            chk("try1_init", INIT, 1'b1);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk("gap_init", INIT, 1'b0);
            chk("gap_fault", FAULT, 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            chk("try2_init", INIT, 1'b1);
            chk("try2_fault", FAULT, 1'b0);
            step();
        end
        IN_VALID  = 1'b1;
        FRAME_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("fault", FAULT, 1'b1);
            chk("fault_init", INIT, 1'b0);
            chk("fault_ready", IN_READY, 1'b0);
            chk("fault_dac", DAC_DATA, 32'h0);
            chk("fault_urun", UNDERRUN_CNT, 16'h0);
            step();
        end
        IN_VALID  = 1'b0;
        FRAME_REQ = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_stream_controller.md
Name: audio_stream_controller

Overview:
Parametrised successor to the codec init sequencer. Drives codec INIT with timeout/retry, then streams multi-channel sample frames from an internal FIFO to the codec on each frame request. Sits between the game's sound-effect mixer (producer) and the codec interface driver (consumer). Reports play/fault status and underruns.

Parameters:
SAMPLE_W, 16, bits per channel sample (signed two's complement)
NUM_CH, 2, channels per frame; frame width FRAME_W = NUM_CH*SAMPLE_W, channel 0 in LSBs
FIFO_DEPTH, 8, frames buffered; power of two, >= 2
PRIME_LEVEL, 4, FIFO occupancy required before playback starts; 1..FIFO_DEPTH
INIT_TIMEOUT, 1000000, cycles to wait for INIT_FINISH per attempt
MAX_RETRIES, 3, re-attempts after the first timeout before fault
RETRY_GAP, 16, cycles INIT is held low between attempts

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
INIT_FINISH  in  1  codec driver reports configuration complete (level)
INIT  out  1  request codec configuration
IN_DATA  in  FRAME_W  frame from mixer
IN_VALID  in  1  IN_DATA valid
IN_READY  out  1  FIFO can accept a frame
FRAME_REQ  in  1  single-cycle pulse: codec consumes one frame
DAC_DATA  out  FRAME_W  frame presented to codec
PLAYING  out  1  high in S_PLAY
FAULT  out  1  high in S_FAULT
UNDERRUN_CNT  out  16  saturating count of starved FRAME_REQ pulses
VOLUME  in  3  attenuation shift (AUDIO_VOLUME_EN only)

Behaviour:
- Reset (async, active-high): state S_BEGIN; INIT=0, IN_READY=0, DAC_DATA=0, PLAYING=0, FAULT=0, UNDERRUN_CNT=0; FIFO empty; timeout, gap, retry counters 0.
- States/transitions (registered, one per clock):
  S_BEGIN -> S_SETUP unconditionally.
  S_SETUP: INIT=1; timeout counter increments. INIT_FINISH=1 -> S_PRIME. Counter reaching INIT_TIMEOUT-1 without INIT_FINISH: if retries==MAX_RETRIES -> S_FAULT, else retries++ -> S_RETRY. INIT_FINISH and timeout on same cycle: INIT_FINISH wins.
  S_RETRY: INIT=0 for exactly RETRY_GAP cycles -> S_SETUP (timeout counter cleared).
  S_PRIME: INIT=1; IN_READY=!full. Occupancy >= PRIME_LEVEL -> S_PLAY.
  S_PLAY: INIT=1, PLAYING=1; terminal until Reset.
  S_FAULT: INIT=0, FAULT=1, IN_READY=0; terminal until Reset.
- INIT_FINISH dropping in S_PRIME/S_PLAY is ignored.
- FIFO push: IN_VALID & IN_READY, in S_PRIME or S_PLAY only. IN_READY = !full in those states, else 0. When full, push refused even if a pop occurs same cycle (IN_READY does not look at FRAME_REQ). Simultaneous push/pop when neither full nor empty: occupancy unchanged.
- FIFO pointers log2(FIFO_DEPTH) bits wrap naturally; occupancy counter log2(FIFO_DEPTH)+1 bits.
- FRAME_REQ in S_PLAY: FIFO non-empty -> pop, DAC_DATA <= head frame on that edge (visible next cycle, 1-cycle latency); empty -> DAC_DATA <= 0, UNDERRUN_CNT++ saturating at 0xFFFF. FRAME_REQ outside S_PLAY ignored; DAC_DATA holds 0.
- DAC_DATA holds between requests. Playback never re-primes after underrun.

Optional Feature:
AUDIO_VOLUME_EN defined: each channel of the popped frame is arithmetic-right-shifted by VOLUME (sign-preserving) before registering into DAC_DATA; VOLUME sampled on the pop cycle; latency unchanged. Undefined: VOLUME port absent, DAC_DATA = raw frame.

Decomposition:
- Package audio_stream_pkg: state enum (S_BEGIN, S_SETUP, S_RETRY, S_PRIME, S_PLAY, S_FAULT), UNDERRUN_W=16 constant.
- Sub-module audio_frame_fifo: synchronous FIFO (FRAME_W, FIFO_DEPTH), push/pop/full/empty/count; controller holds FSM, counters, output register.

Test Plan:
- Reset, INIT_FINISH rises 10 cycles after S_SETUP -> INIT=1 from cycle 1; S_PRIME entered; no FAULT.
- INIT_TIMEOUT=20, MAX_RETRIES=1, INIT_FINISH never -> INIT high 20, low 16, high 20, then FAULT=1, INIT=0, IN_READY=0 permanently.
- Push frames 0x0001_0002..0x0004_0005 (PRIME_LEVEL=4) -> PLAYING next cycle; FRAME_REQ -> DAC_DATA=0x00010002 one cycle later, frames in order.
- Fill to 8 frames -> IN_READY=0; FRAME_REQ with IN_VALID same cycle -> push refused, occupancy 7.
- Drain FIFO, then 3 FRAME_REQ pulses -> DAC_DATA=0, UNDERRUN_CNT=3; preload near 0xFFFF -> saturates at 0xFFFF.
- AUDIO_VOLUME_EN, VOLUME=2, frame channel 0x8000 -> DAC channel 0xE000; Reset asserted mid-PLAY -> all outputs zero asynchronously.
